// File: rtl/dp_share_arbiter.sv
// Round-robin front end for a shared fixed-latency datapath chain. Each issued item carries
// its requester id down a tag pipeline that mirrors the chain, so each result returns to its owner.
module dp_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       hold,
    output logic [DATA_W-1:0]          dp_in,
    input  logic [DATA_W-1:0]          dp_out,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] dp_in_q, dp_in_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [PIPE_LAT:0] tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [PIPE_LAT+1];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand;
    logic              xfer;

    // Search starts at ptr and wraps by compare so non-power-of-2 counts stay in range.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
        end
    end

    assign xfer      = win_found && !hold;
    assign req_ready = xfer ? (NUM_REQ'(1) << win_id) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        dp_in_d     = dp_in_q;
        grant_id_d  = grant_id_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (xfer) begin
            ptr_d      = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
            dp_in_d    = req_data[win_id*DATA_W +: DATA_W];
            grant_id_d = win_id;
        end
        if (tag_vld_q[PIPE_LAT]) begin
            rsp_valid_d = NUM_REQ'(1) << tag_id_q[PIPE_LAT];
            rsp_data_d  = dp_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            dp_in_q     <= '0;
            grant_id_q  <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) tag_id_q[k] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            dp_in_q     <= dp_in_d;
            grant_id_q  <= grant_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            // Stage k lines up with dp_in delayed k cycles; stage PIPE_LAT lines up with dp_out.
            tag_vld_q   <= {tag_vld_q[PIPE_LAT-1:0], xfer};
            tag_id_q[0] <= win_id;
            for (int k = 1; k <= PIPE_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign dp_in     = dp_in_q;
    assign grant_id  = grant_id_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|tag_vld_q) || (|rsp_valid_q);

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Scoreboard bench: two arbiter instances (4 req / lat 2 and 3 req / lat 5) each feeding a chain
// model of register stages followed by OR 8'h33; monitors pop expected responses per instance.
module tb_dp_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [7:0] oh;
        logic [7:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // Instance A: NUM_REQ=4, PIPE_LAT=2
    logic [3:0]  a_valid = '0;
    logic [31:0] a_data = '0;
    logic        a_hold = 1'b0;
    logic [3:0]  a_ready, a_rsp_valid;
    logic [7:0]  a_dp_in, a_dp_out, a_rsp_data;
    logic [1:0]  a_gid;
    logic        a_busy;
    logic [7:0]  a_ch [2];

    always @(posedge clk) begin
        a_ch[0] <= a_dp_in;
        a_ch[1] <= a_ch[0];
    end
    assign a_dp_out = a_ch[1] | 8'h33;

    dp_share_arbiter #(.NUM_REQ(4), .DATA_W(8), .PIPE_LAT(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .hold(a_hold), .dp_in(a_dp_in), .dp_out(a_dp_out), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .grant_id(a_gid), .busy(a_busy)
    );

    // Instance B: NUM_REQ=3, PIPE_LAT=5
    logic [2:0]  b_valid = '0;
    logic [23:0] b_data = '0;
    logic        b_hold = 1'b0;
    logic [2:0]  b_ready, b_rsp_valid;
    logic [7:0]  b_dp_in, b_dp_out, b_rsp_data;
    logic [1:0]  b_gid;
    logic        b_busy;
    logic [7:0]  b_ch [5];

    always @(posedge clk) begin
        b_ch[0] <= b_dp_in;
        for (int k = 1; k < 5; k++) b_ch[k] <= b_ch[k-1];
    end
    assign b_dp_out = b_ch[4] | 8'h33;

    dp_share_arbiter #(.NUM_REQ(3), .DATA_W(8), .PIPE_LAT(5)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .hold(b_hold), .dp_in(b_dp_in), .dp_out(b_dp_out), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .grant_id(b_gid), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Expect a handshake on requester id this cycle; queue its response.
    task automatic a_issue(input int id);
        exp_t e;
        chk("a_ready", 32'(a_ready), 32'(1) << id);
        e.cyc  = cyc + 4;
        e.oh   = 8'(1 << id);
        e.data = a_data[id*8 +: 8] | 8'h33;
        qa.push_back(e);
    endtask

    task automatic b_issue(input int id);
        exp_t e;
        chk("b_ready", 32'(b_ready), 32'(1) << id);
        e.cyc  = cyc + 7;
        e.oh   = 8'(1 << id);
        e.data = b_data[id*8 +: 8] | 8'h33;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid != '0) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rsp_cycle", cyc, e.cyc);
                chk("a_rsp_valid", 32'(a_rsp_valid), 32'(e.oh));
                chk("a_rsp_data", 32'(a_rsp_data), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid != '0) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rsp_cycle", cyc, e.cyc);
                chk("b_rsp_valid", 32'(b_rsp_valid), 32'(e.oh));
                chk("b_rsp_data", 32'(b_rsp_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int h0;
        #3;
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_dp_in", 32'(a_dp_in), 32'd0);
        chk("rst_grant_id", 32'(a_gid), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single request from req0
        tick();
        a_data[7:0] = 8'h40;
        a_valid = 4'b0001;
        #1;
        a_issue(0);
        tick();
        a_valid = '0;
        #1;
        chk("t1_grant_id", 32'(a_gid), 32'd0);
        chk("t1_dp_in", 32'(a_dp_in), 32'h40);
        repeat (6) tick();

        // All requesters continuously valid from a fresh pointer
        do_reset();
        tick();
        a_data = 32'h3020_1000;
        a_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            a_issue(k % 4);
            tick();
            #1;
            chk("t2_grant_id", 32'(a_gid), 32'(k % 4));
        end
        a_valid = '0;
        repeat (8) tick();

        // Pointer sequencing: req1, then 1010 -> req3 before req1
        tick();
        a_data = 32'h8000_0500;
        a_valid = 4'b0010;
        #1;
        a_issue(1);
        tick();
        a_valid = 4'b1010;
        #1;
        a_issue(3);
        tick();
        #1;
        a_issue(1);
        tick();
        a_valid = '0;
        repeat (6) tick();

        // Three in flight, then hold and drain
        tick();
        a_data = 32'hC080_4004;
        a_valid = 4'b1111;
        #1;
        h0 = cyc;
        a_issue(2);
        tick();
        #1;
        a_issue(3);
        tick();
        #1;
        a_issue(0);
        tick();
        a_hold = 1'b1;
        #1;
        chk("t4_hold_ready", 32'(a_ready), 32'd0);
        repeat (3) begin
            tick();
            #1;
            chk("t4_hold_ready_drain", 32'(a_ready), 32'd0);
        end
        chk("t4_cycle", cyc, h0 + 6);
        chk("t4_busy_last", 32'(a_busy), 32'd1);
        tick();
        #1;
        chk("t4_busy_clear", 32'(a_busy), 32'd0);
        a_hold = 1'b0;
        #1;
        a_issue(1);
        tick();
        a_valid = '0;
        repeat (6) tick();

        // Reset with two items in flight
        tick();
        a_valid = 4'b1111;
        #1;
        chk("t5_ready0", 32'(a_ready), 32'b0100);
        tick();
        #1;
        chk("t5_ready1", 32'(a_ready), 32'b1000);
        tick();
        a_valid = '0;
        #1;
        chk("t5_busy_pre", 32'(a_busy), 32'd1);
        chk("t5_dp_in_pre", 32'(a_dp_in), 32'hC0);
        chk("t5_gid_pre", 32'(a_gid), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_dp_in", 32'(a_dp_in), 32'd0);
        chk("t5_gid", 32'(a_gid), 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (10) tick();

        // Three requesters, latency 5, pointer wrap 2 -> 0
        tick();
        b_data = 24'h0C_0050;
        b_valid = 3'b100;
        #1;
        b_issue(2);
        tick();
        b_valid = 3'b101;
        #1;
        chk("t6_grant_id", 32'(b_gid), 32'd2);
        b_issue(0);
        tick();
        #1;
        b_issue(2);
        tick();
        #1;
        b_issue(0);
        tick();
        b_valid = '0;
        repeat (10) tick();

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
